rep_loop_ctrl: RTL and testbench

Iteration sequencer sitting directly upstream of the CX count register. It loads CX with a repeat count, issues one iteration request per count to the execution datapath over a req/ack handshake, and decrements CX after each acknowledged iteration. It consumes CX's zero flag to terminate the loop.

---
 rtl/rep_loop_ctrl.sv | 149 ++++++++++++++
 tb/tb_rep_loop_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_loop_ctrl.sv
// Repeat-loop sequencer driving the CX count register and an iteration req/ack handshake.
// Optional REPE/REPNE-style conditional stop is enabled with `define LOOP_COND_EN.
module rep_loop_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] count_in,
  input  logic       cx_iszero,
  input  logic       iter_ack,
  input  logic       abort,
`ifdef LOOP_COND_EN
  input  logic       cond_flag,
  input  logic [1:0] cond_mode,
`endif
  output logic [7:0] cx_load_data,
  output logic       cx_load_enable,
  output logic       cx_count_enable,
  output logic       iter_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] iter_done_cnt,
  output logic [1:0] exit_code
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EXIT_W = 2;

  localparam logic [EXIT_W-1:0] EXIT_COUNT = 2'b00;
  localparam logic [EXIT_W-1:0] EXIT_ABORT = 2'b01;
  localparam logic [EXIT_W-1:0] EXIT_COND  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ISSUE,
    S_DEC,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              abort_flag_q, abort_flag_d;
  logic              stop_flag_q, stop_flag_d;
  logic [CNT_W-1:0]  load_data_d;
  logic [CNT_W-1:0]  iter_cnt_d;
  logic [EXIT_W-1:0] exit_d;
  logic              stop_hit_c;

  // Stop rule evaluated on the acknowledged iteration
`ifdef LOOP_COND_EN
  always_comb begin
    stop_hit_c = 1'b0;
    case (cond_mode)
      2'b01:   stop_hit_c = ~cond_flag;
      2'b10:   stop_hit_c = cond_flag;
      default: stop_hit_c = 1'b0;
    endcase
  end
`else
  assign stop_hit_c = 1'b0;
`endif

  // Next-state and next-data logic
  always_comb begin
    state_d      = state_q;
    abort_flag_d = abort_flag_q;
    stop_flag_d  = stop_flag_q;
    load_data_d  = cx_load_data;
    iter_cnt_d   = iter_done_cnt;
    exit_d       = exit_code;

    if (state_q != S_IDLE && abort) abort_flag_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_data_d  = count_in;
          iter_cnt_d   = '0;
          abort_flag_d = 1'b0;
          stop_flag_d  = 1'b0;
          exit_d       = EXIT_COUNT;
          state_d      = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (abort_flag_q) begin
          exit_d  = EXIT_ABORT;
          state_d = S_DONE;
        end else if (stop_flag_q) begin
          exit_d  = EXIT_COND;
          state_d = S_DONE;
        end else if (cx_iszero) begin
          exit_d  = EXIT_COUNT;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (iter_ack) begin
          iter_cnt_d = CNT_W'(iter_done_cnt + 1'b1);
          if (stop_hit_c) stop_flag_d = 1'b1;
          state_d = S_DEC;
        end
      end
      S_DEC:   state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and loop bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      abort_flag_q <= 1'b0;
      stop_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      abort_flag_q <= abort_flag_d;
      stop_flag_q  <= stop_flag_d;
    end
  end

  // Outputs registered from the next state so they align with the state they decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_load_data    <= '0;
      cx_load_enable  <= 1'b0;
      cx_count_enable <= 1'b0;
      iter_req        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      iter_done_cnt   <= '0;
      exit_code       <= EXIT_COUNT;
    end else begin
      cx_load_data    <= load_data_d;
      cx_load_enable  <= (state_d == S_LOAD);
      cx_count_enable <= (state_d == S_DEC);
      iter_req        <= (state_d == S_ISSUE);
      busy            <= (state_d != S_IDLE);
      done            <= (state_d == S_DONE);
      iter_done_cnt   <= iter_cnt_d;
      exit_code       <= exit_d;
    end
  end

endmodule

// File: tb/tb_rep_loop_ctrl.sv
// Directed bench for rep_loop_ctrl with a behavioural CX register model.
module tb_rep_loop_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic       cx_iszero;
  logic       iter_ack = 1'b0;
  logic       abort = 1'b0;
`ifdef LOOP_COND_EN
  logic       cond_flag = 1'b1;
  logic [1:0] cond_mode = 2'b00;
`endif
  logic [7:0] cx_load_data;
  logic       cx_load_enable;
  logic       cx_count_enable;
  logic       iter_req;
  logic       busy;
  logic       done;
  logic [7:0] iter_done_cnt;
  logic [1:0] exit_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Statistics gathered by the loop driver
  int done_cycle, req_cycles, req_rises, ld_pulses, dec_pulses;

  logic [7:0] cx;

  rep_loop_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .count_in        (count_in),
    .cx_iszero       (cx_iszero),
    .iter_ack        (iter_ack),
    .abort           (abort),
`ifdef LOOP_COND_EN
    .cond_flag       (cond_flag),
    .cond_mode       (cond_mode),
`endif
    .cx_load_data    (cx_load_data),
    .cx_load_enable  (cx_load_enable),
    .cx_count_enable (cx_count_enable),
    .iter_req        (iter_req),
    .busy            (busy),
    .done            (done),
    .iter_done_cnt   (iter_done_cnt),
    .exit_code       (exit_code)
  );

  always #5 clk = ~clk;

  // CX register model
  always @(posedge clk or negedge reset) begin
    if (!reset)               cx <= 8'd0;
    else if (cx_load_enable)  cx <= cx_load_data;
    else if (cx_count_enable) cx <= cx - 8'd1;
  end
  assign cx_iszero = (cx == 8'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ack tied high plus a start pulse while busy; 1: ack after 4 wait cycles; 2: abort in 2nd ISSUE
  task automatic run_loop(input logic [7:0] n, input int mode);
    int  wait_cnt = 0;
    bit  aborted  = 0;
    bit  prev_req = 0;
    done_cycle = 0; req_cycles = 0; req_rises = 0; ld_pulses = 0; dec_pulses = 0;
    iter_ack = (mode == 0);
    start = 1'b1;
    count_in = n;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (iter_req) req_cycles++;
      if (iter_req && !prev_req) req_rises++;
      if (cx_load_enable) ld_pulses++;
      if (cx_count_enable) dec_pulses++;
      prev_req = iter_req;
      if (done) begin
        done_cycle = cyc;
        break;
      end
      start = 1'b0;
      abort = 1'b0;
`ifdef LOOP_COND_EN
      cond_flag = (iter_done_cnt != 8'd2);
`endif
      if (mode == 0) begin
        if (cyc == 3) begin
          start = 1'b1;
          count_in = 8'd7;
        end
      end else if (mode == 1) begin
        iter_ack = 1'b0;
        if (iter_req) begin
          if (wait_cnt == 4) begin
            iter_ack = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        iter_ack = 1'b0;
        if (iter_req) begin
          if (iter_done_cnt == 8'd1 && !aborted) begin
            abort = 1'b1;
            aborted = 1;
          end else begin
            iter_ack = 1'b1;
          end
        end
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    iter_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (iter_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", iter_req); end
    n_checks++; if (cx_load_enable !== 1'b0 || cx_count_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b%b exp=00", cx_load_enable, cx_count_enable); end
    n_checks++; if (cx_load_data !== 8'd0) begin n_fail++; $display("FAIL reset_load_data got=%0d exp=0", cx_load_data); end
    n_checks++; if (iter_done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", iter_done_cnt); end
    n_checks++; if (exit_code !== 2'b00) begin n_fail++; $display("FAIL reset_exit got=%b exp=00", exit_code); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_count3();
    run_loop(8'd3, 0);
    n_checks++; if (done_cycle != 12) begin n_fail++; $display("FAIL c3_done_cycle got=%0d exp=12", done_cycle); end
    n_checks++; if (req_cycles != 3) begin n_fail++; $display("FAIL c3_req_cycles got=%0d exp=3", req_cycles); end
    n_checks++; if (dec_pulses != 3) begin n_fail++; $display("FAIL c3_dec_pulses got=%0d exp=3", dec_pulses); end
    n_checks++; if (ld_pulses != 1) begin n_fail++; $display("FAIL c3_load_pulses got=%0d exp=1", ld_pulses); end
    n_checks++; if (iter_done_cnt !== 8'd3) begin n_fail++; $display("FAIL c3_cnt got=%0d exp=3", iter_done_cnt); end
    n_checks++; if (exit_code !== 2'b00) begin n_fail++; $display("FAIL c3_exit got=%b exp=00", exit_code); end
    n_checks++; if (cx_load_data !== 8'd3) begin n_fail++; $display("FAIL c3_start_while_busy got=%0d exp=3", cx_load_data); end
    n_checks++; if (cx !== 8'd0) begin n_fail++; $display("FAIL c3_cx got=%0d exp=0", cx); end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL c3_after_done got busy=%b done=%b exp=0,0", busy, done); end
    n_checks++; if (exit_code !== 2'b00) begin n_fail++; $display("FAIL c3_exit_hold got=%b exp=00", exit_code); end
  endtask

  task automatic test_count0();
    run_loop(8'd0, 0);
    n_checks++; if (done_cycle != 3) begin n_fail++; $display("FAIL c0_done_cycle got=%0d exp=3", done_cycle); end
    n_checks++; if (req_cycles != 0) begin n_fail++; $display("FAIL c0_req_cycles got=%0d exp=0", req_cycles); end
    n_checks++; if (ld_pulses != 1) begin n_fail++; $display("FAIL c0_load_pulses got=%0d exp=1", ld_pulses); end
    n_checks++; if (iter_done_cnt !== 8'd0) begin n_fail++; $display("FAIL c0_cnt got=%0d exp=0", iter_done_cnt); end
    n_checks++; if (exit_code !== 2'b00) begin n_fail++; $display("FAIL c0_exit got=%b exp=00", exit_code); end
    tick();
  endtask

  task automatic test_delayed_ack();
    run_loop(8'd5, 1);
    n_checks++; if (done_cycle != 38) begin n_fail++; $display("FAIL dly_done_cycle got=%0d exp=38", done_cycle); end
    n_checks++; if (req_rises != 5) begin n_fail++; $display("FAIL dly_req_rises got=%0d exp=5", req_rises); end
    n_checks++; if (req_cycles != 25) begin n_fail++; $display("FAIL dly_req_cycles got=%0d exp=25", req_cycles); end
    n_checks++; if (iter_done_cnt !== 8'd5) begin n_fail++; $display("FAIL dly_cnt got=%0d exp=5", iter_done_cnt); end
    n_checks++; if (exit_code !== 2'b00) begin n_fail++; $display("FAIL dly_exit got=%b exp=00", exit_code); end
    tick();
  endtask

  task automatic test_abort();
    run_loop(8'd10, 2);
    n_checks++; if (done_cycle != 10) begin n_fail++; $display("FAIL abt_done_cycle got=%0d exp=10", done_cycle); end
    n_checks++; if (iter_done_cnt !== 8'd2) begin n_fail++; $display("FAIL abt_cnt got=%0d exp=2", iter_done_cnt); end
    n_checks++; if (exit_code !== 2'b01) begin n_fail++; $display("FAIL abt_exit got=%b exp=01", exit_code); end
    n_checks++; if (cx !== 8'd8) begin n_fail++; $display("FAIL abt_cx got=%0d exp=8", cx); end
    n_checks++; if (dec_pulses != 2) begin n_fail++; $display("FAIL abt_dec_pulses got=%0d exp=2", dec_pulses); end
    tick();
  endtask

  task automatic test_reset_midloop();
    bit seen_req = 0;
    iter_ack = 1'b0;
    start = 1'b1;
    count_in = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      if (iter_req) seen_req = 1;
      else tick();
    end
    n_checks++; if (!seen_req) begin n_fail++; $display("FAIL rst_mid_req_seen got=0 exp=1"); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (iter_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async got req=%b busy=%b exp=0,0", iter_req, busy); end
    n_checks++; if (cx_load_data !== 8'd0 || iter_done_cnt !== 8'd0 || exit_code !== 2'b00 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_data got ld=%0d cnt=%0d exit=%b done=%b exp=0,0,00,0",
                         cx_load_data, iter_done_cnt, exit_code, done); end
    n_checks++; if (cx !== 8'd0) begin n_fail++; $display("FAIL rst_mid_cx got=%0d exp=0", cx); end
    #1 reset = 1'b1;
    tick();
    run_loop(8'd1, 0);
    n_checks++; if (done_cycle != 6) begin n_fail++; $display("FAIL rst_mid_rerun_cycle got=%0d exp=6", done_cycle); end
    n_checks++; if (iter_done_cnt !== 8'd1 || exit_code !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_rerun got cnt=%0d exit=%b exp=1,00", iter_done_cnt, exit_code); end
    tick();
  endtask

`ifdef LOOP_COND_EN
  task automatic test_cond_stop();
    cond_mode = 2'b01;
    run_loop(8'd6, 0);
    n_checks++; if (exit_code !== 2'b10) begin n_fail++; $display("FAIL cond_exit got=%b exp=10", exit_code); end
    n_checks++; if (iter_done_cnt !== 8'd3) begin n_fail++; $display("FAIL cond_cnt got=%0d exp=3", iter_done_cnt); end
    n_checks++; if (cx !== 8'd3) begin n_fail++; $display("FAIL cond_cx got=%0d exp=3", cx); end
    n_checks++; if (done_cycle != 12) begin n_fail++; $display("FAIL cond_done_cycle got=%0d exp=12", done_cycle); end
    cond_mode = 2'b00;
    cond_flag = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_count3();
    test_count0();
    test_delayed_ack();
    test_abort();
    test_reset_midloop();
`ifdef LOOP_COND_EN
    test_cond_stop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
